// File: rtl/rgb_sense_ctrl_if.sv
// rgb_sense_ctrl_if
// Groups the control, sensor and result signals of rgb_sense_ctrl.
//   slave  : the controller side (takes run/sensor_out, drives everything else)
//   master : the system side (drives run/sensor_out, observes the results)
// Signals:
//   run        level request to measure frames back to back
//   sensor_out raw square wave from the colour sensor (asynchronous)
//   s0, s1     sensor frequency scaling pins
//   s2, s3     sensor filter select pins
//   busy       controller is not idle
//   R/G/B_detect  published 8-bit intensities
//   valid      one-cycle pulse marking freshly published intensities
`timescale 1ns/1ps

interface rgb_sense_ctrl_if;
    logic       run;
    logic       sensor_out;
    logic       s0;
    logic       s1;
    logic       s2;
    logic       s3;
    logic       busy;
    logic [7:0] R_detect;
    logic [7:0] G_detect;
    logic [7:0] B_detect;
    logic       valid;

    modport slave (
        input  run,
        input  sensor_out,
        output s0,
        output s1,
        output s2,
        output s3,
        output busy,
        output R_detect,
        output G_detect,
        output B_detect,
        output valid
    );

    modport master (
        output run,
        output sensor_out,
        input  s0,
        input  s1,
        input  s2,
        input  s3,
        input  busy,
        input  R_detect,
        input  G_detect,
        input  B_detect,
        input  valid
    );
endinterface

// File: rtl/rgb_sense_ctrl.sv
// rgb_sense_ctrl
// Sequences a TCS3200-style colour sensor through its red, green and blue
// filters, counts sensor pulses in a fixed gate window per filter and
// publishes all three 8-bit intensities together once per frame.
//
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   rgb_sense_ctrl_if.slave (run, sensor_out in; s0..s3, busy,
//         R/G/B_detect, valid out)
//
// Parameters:
//   SETTLE_CYCLES  clocks held after each filter change before counting (>=1)
//   GATE_CYCLES    clocks in each counting window (>=1)
//   CNT_W          edge counter width, counter saturates at all-ones
//   SHIFT          right shift applied to the count before 8-bit saturation
//
// Build option:
//   RGB_AVG_EN     when defined, each published value is the rounded mean of
//                  the previous output and the new frame's value.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for run, filter code 00, nothing counted
// SET_R  | red filter selected, settling, counter held at 0
// GATE_R | counting sensor edges through the red filter
// SET_G  | green filter selected, settling, counter held at 0
// GATE_G | counting sensor edges through the green filter
// SET_B  | blue filter selected, settling, counter held at 0
// GATE_B | counting sensor edges through the blue filter
// DONE   | one cycle: publish shadows, valid follows next cycle
`timescale 1ns/1ps

module rgb_sense_ctrl #(
    parameter int SETTLE_CYCLES = 1000,
    parameter int GATE_CYCLES   = 100000,
    parameter int CNT_W         = 20,
    parameter int SHIFT         = 4
) (
    input  logic             clk,
    input  logic             rst,
    rgb_sense_ctrl_if.slave  bus
);

    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int TMR_W  = (SET_W > GATE_W) ? SET_W : GATE_W;

    // Shared down-counter: loaded with N-1 on entry, phase ends at zero.
    localparam logic [TMR_W-1:0] SET_LOAD  = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD = TMR_W'(GATE_CYCLES - 1);

    localparam logic [1:0] FILT_R = 2'b00;
    localparam logic [1:0] FILT_G = 2'b11;
    localparam logic [1:0] FILT_B = 2'b01;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SET_R  = 3'd1,
        GATE_R = 3'd2,
        SET_G  = 3'd3,
        GATE_G = 3'd4,
        SET_B  = 3'd5,
        GATE_B = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [2:0]         sync_q;
    logic               edge_det;
    logic               tmr_tc;
    logic [7:0]         shd_r_q, shd_r_d;
    logic [7:0]         shd_g_q, shd_g_d;
    logic [7:0]         shd_b_q, shd_b_d;
    logic [7:0]         r_q, r_d;
    logic [7:0]         g_q, g_d;
    logic [7:0]         b_q, b_d;
    logic               valid_q, valid_d;
    logic [1:0]         filt;

    // Count scaled down by SHIFT, clamped to 8 bits.
    function automatic logic [7:0] sat8(input logic [CNT_W-1:0] c);
        logic [31:0] v;
        v = 32'(c) >> SHIFT;
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

`ifdef RGB_AVG_EN
    // 9-bit sum so the rounded mean can never overflow.
    function automatic logic [7:0] avg8(input logic [7:0] y_old,
                                        input logic [7:0] y_new);
        logic [8:0] sum;
        sum = {1'b0, y_old} + {1'b0, y_new} + 9'd1;
        return sum[8:1];
    endfunction
`endif

    // sync_q[0] is the metastability catcher; the edge is taken between the
    // second and third flop, giving a 3-clock input-to-count latency.
    assign edge_det = sync_q[1] & ~sync_q[2];
    assign tmr_tc   = (tmr_q == '0);

    always_comb begin
        cnt_inc = cnt_q;
        if (edge_det && (cnt_q != '1)) begin
            cnt_inc = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            sync_q  <= '0;
            shd_r_q <= '0;
            shd_g_q <= '0;
            shd_b_q <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[1:0], bus.sensor_out};
            shd_r_q <= shd_r_d;
            shd_g_q <= shd_g_d;
            shd_b_q <= shd_b_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = '0;
        shd_r_d = shd_r_q;
        shd_g_d = shd_g_q;
        shd_b_d = shd_b_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (bus.run) begin
                    state_d = SET_R;
                    tmr_d   = SET_LOAD;
                end
            end
            SET_R, SET_G, SET_B: begin
                if (tmr_tc) begin
                    tmr_d = GATE_LOAD;
                    case (state_q)
                        SET_R:   state_d = GATE_R;
                        SET_G:   state_d = GATE_G;
                        default: state_d = GATE_B;
                    endcase
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            GATE_R, GATE_G, GATE_B: begin
                cnt_d = cnt_inc;
                if (tmr_tc) begin
                    // Latch includes an edge detected on this last cycle.
                    cnt_d = '0;
                    tmr_d = SET_LOAD;
                    case (state_q)
                        GATE_R: begin
                            shd_r_d = sat8(cnt_inc);
                            state_d = SET_G;
                        end
                        GATE_G: begin
                            shd_g_d = sat8(cnt_inc);
                            state_d = SET_B;
                        end
                        default: begin
                            shd_b_d = sat8(cnt_inc);
                            state_d = DONE;
                            tmr_d   = '0;
                        end
                    endcase
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            DONE: begin
`ifdef RGB_AVG_EN
                r_d = avg8(r_q, shd_r_q);
                g_d = avg8(g_q, shd_g_q);
                b_d = avg8(b_q, shd_b_q);
`else
                r_d = shd_r_q;
                g_d = shd_g_q;
                b_d = shd_b_q;
`endif
                valid_d = 1'b1;
                if (bus.run) begin
                    state_d = SET_R;
                    tmr_d   = SET_LOAD;
                end else begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    always_comb begin
        filt = FILT_R;
        case (state_q)
            SET_G, GATE_G: filt = FILT_G;
            SET_B, GATE_B: filt = FILT_B;
            default:       filt = FILT_R;
        endcase
    end

    assign bus.s0       = 1'b1;
    assign bus.s1       = 1'b0;
    assign bus.s2       = filt[1];
    assign bus.s3       = filt[0];
    assign bus.busy     = (state_q != IDLE);
    assign bus.R_detect = r_q;
    assign bus.G_detect = g_q;
    assign bus.B_detect = b_q;
    assign bus.valid    = valid_q;

endmodule

// File: tb/tb_rgb_sense_ctrl.sv
// Testbench for rgb_sense_ctrl: random sensor waveforms per channel, a
// frame-schedule reference model over the recorded sensor samples, plus two
// extra instances that exercise counter and 8-bit saturation.
`timescale 1ns/1ps

module tb_rgb_sense_ctrl;

    localparam int S     = 10;
    localparam int G     = 100;
    localparam int CW    = 8;
    localparam int SH    = 0;
    localparam int FRAME = 3 * (S + G) + 1;

    localparam int GA     = 200;
    localparam int CWA    = 6;
    localparam int FRAMEA = 3 * (S + GA) + 1;
    localparam int GB     = 600;
    localparam int CWB    = 10;
    localparam int FRAMEB = 3 * (S + GB) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sens = 1'b0;
    logic run_m = 1'b0;
    logic run_x = 1'b0;

    always #5 clk = ~clk;

    rgb_sense_ctrl_if bus_m ();
    rgb_sense_ctrl_if bus_a ();
    rgb_sense_ctrl_if bus_b ();

    assign bus_m.run = run_m;
    assign bus_a.run = run_x;
    assign bus_b.run = run_x;
    assign bus_m.sensor_out = sens;
    assign bus_a.sensor_out = sens;
    assign bus_b.sensor_out = sens;

    rgb_sense_ctrl #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(CW), .SHIFT(SH))
        dut (.clk(clk), .rst(rst), .bus(bus_m));
    rgb_sense_ctrl #(.SETTLE_CYCLES(S), .GATE_CYCLES(GA), .CNT_W(CWA), .SHIFT(0))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    rgb_sense_ctrl #(.SETTLE_CYCLES(S), .GATE_CYCLES(GB), .CNT_W(CWB), .SHIFT(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int total = 0;
    int bad   = 0;

    // Cycle bookkeeping: hist[c] is the sensor level sampled at edge c;
    // vcnt counts valid pulses of the main instance.
    bit hist [0:65535];
    int n    = 0;
    int vcnt = 0;

    always @(posedge clk) begin
        if (n < 65536) hist[n] = sens;
        if (bus_m.valid) vcnt = vcnt + 1;
        n = n + 1;
    end

    // Sensor generator: per=0 low, per=1 random bits, per>=2 square wave.
    int per = 2;
    int ph  = 0;
    always @(negedge clk) begin
        if (per == 0) begin
            sens = 1'b0;
        end else if (per == 1) begin
            sens = 1'($urandom_range(0, 1));
        end else begin
            ph   = (ph + 1) % per;
            sens = (ph < per / 2);
        end
    end

    int ym [3];
    int ya [3];
    int yb [3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (n - 1 < c) @(negedge clk);
    endtask

    // Rising transitions seen by the block in gate cycles [st, st+len).
    function automatic int edges_in(input int st, input int len);
        int e = 0;
        for (int c = st; c < st + len; c++) begin
            if (hist[c - 1] && !hist[c - 2]) e++;
        end
        return e;
    endfunction

    function automatic int sat8m(input int cnt, input int cw, input int sh);
        int top;
        int v;
        top = (1 << cw) - 1;
        v = (cnt > top) ? top : cnt;
        v = v >> sh;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int pub(input int old_v, input int new_v);
`ifdef RGB_AVG_EN
        return (old_v + new_v + 1) >> 1;
`else
        return new_v + 0 * old_v;
`endif
    endfunction

    // Runs nf back-to-back frames on the main instance; run drops in the
    // middle of GATE_G of the last frame.
    task automatic run_frames(input int nf);
        int e0;
        int v0;
        int base;
        int chs;
        int ex;
        int code [3];
        logic [7:0] got [3];
        code[0] = 0; code[1] = 3; code[2] = 1;
        v0 = vcnt;
        per = $urandom_range(0, 12);
        e0 = n;
        run_m = 1'b1;
        for (int k = 0; k < nf; k++) begin
            base = e0 + FRAME * k;
            for (int ch = 0; ch < 3; ch++) begin
                chs = base + ch * (S + G);
                wait_cyc(chs);
                per = $urandom_range(0, 12);
                wait_cyc(chs + S / 2);
                check_val("filter_set", {bus_m.s2, bus_m.s3}, code[ch]);
                check_val("busy_set", bus_m.busy, 1);
                wait_cyc(chs + S + G / 2);
                check_val("filter_gate", {bus_m.s2, bus_m.s3}, code[ch]);
                check_val("scale_pins", {bus_m.s0, bus_m.s1}, 2'b10);
                if (k == nf - 1 && ch == 1) run_m = 1'b0;
            end
            wait_cyc(base + FRAME - 1);
            check_val("valid_in_done", bus_m.valid, 0);
            wait_cyc(base + FRAME);
            check_val("valid_at_331", bus_m.valid, 1);
            check_val("valid_count_prior", vcnt, v0 + k);
            got[0] = bus_m.R_detect;
            got[1] = bus_m.G_detect;
            got[2] = bus_m.B_detect;
            for (int ch = 0; ch < 3; ch++) begin
                ex = pub(ym[ch], sat8m(edges_in(base + ch * (S + G) + S, G), CW, SH));
                ym[ch] = ex;
                check_val($sformatf("value_ch%0d", ch), got[ch], ex);
            end
        end
        wait_cyc(e0 + FRAME * nf + 1);
        check_val("idle_after_drop", bus_m.busy, 0);
        check_val("valid_one_cycle", bus_m.valid, 0);
        wait_cyc(e0 + FRAME * nf + 40);
        check_val("valid_count_total", vcnt, v0 + nf);
        check_val("hold_R", bus_m.R_detect, ym[0]);
        check_val("hold_B", bus_m.B_detect, ym[2]);
    endtask

    initial begin
        int e0;
        int ex;
        for (int i = 0; i < 3; i++) begin
            ym[i] = 0; ya[i] = 0; yb[i] = 0;
        end

        // Reset held with the sensor toggling, then released with run=0.
        per = 2;
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(30);
        check_val("rst_busy", bus_m.busy, 0);
        check_val("rst_filter", {bus_m.s2, bus_m.s3}, 0);
        check_val("rst_rgb", {bus_m.R_detect, bus_m.G_detect, bus_m.B_detect}, 0);
        check_val("rst_valid_count", vcnt, 0);
        check_val("rst_aux_busy", {bus_a.busy, bus_b.busy}, 0);

        // Single frames, then a continuous run of three frames.
        for (int i = 0; i < 3; i++) run_frames(1);
        run_frames(3);

        // Saturation: 100 edges into a 6-bit counter, 300 edges into sat8.
        per = 2;
        wait_cyc(n + 5);
        e0 = n;
        run_x = 1'b1;
        wait_cyc(e0 + 5);
        run_x = 1'b0;
        wait_cyc(e0 + FRAMEA);
        check_val("sat_cnt_valid", bus_a.valid, 1);
        ex = pub(ya[0], sat8m(edges_in(e0 + S, GA), CWA, 0));
        ya[0] = ex;
        check_val("sat_cnt_R", bus_a.R_detect, ex);
        ex = pub(ya[2], sat8m(edges_in(e0 + 2 * (S + GA) + S, GA), CWA, 0));
        ya[2] = ex;
        check_val("sat_cnt_B", bus_a.B_detect, ex);
        wait_cyc(e0 + FRAMEB);
        check_val("sat8_valid", bus_b.valid, 1);
        ex = pub(yb[1], sat8m(edges_in(e0 + (S + GB) + S, GB), CWB, 0));
        yb[1] = ex;
        check_val("sat8_G", bus_b.G_detect, ex);

        // Reset in the middle of GATE_B: no publish, everything back to zero.
        per = 1;
        e0 = n;
        run_m = 1'b1;
        wait_cyc(e0 + 2 * (S + G) + S + 50);
        rst = 1'b1;
        wait_cyc(e0 + 2 * (S + G) + S + 51);
        check_val("midrst_busy", bus_m.busy, 0);
        check_val("midrst_valid", bus_m.valid, 0);
        check_val("midrst_rgb", {bus_m.R_detect, bus_m.G_detect, bus_m.B_detect}, 0);
        check_val("midrst_filter", {bus_m.s2, bus_m.s3}, 0);
        run_m = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ym[i] = 0; ya[i] = 0; yb[i] = 0;
        end
        ex = vcnt;
        wait_cyc(n + 400);
        check_val("midrst_no_publish", vcnt, ex);
        check_val("midrst_still_idle", bus_m.busy, 0);

        // One more frame from reset (smoothing starts from zero when enabled).
        run_frames(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
